// File: rtl/param_sync_fifo_if.sv
// Handshake/status bundle for param_sync_fifo. The FIFO uses the slave
// modport and the producer/consumer side uses the master modport.
interface param_sync_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
);
  logic                     cs;
  logic                     wr_en;
  logic                     rd_en;
  logic                     flush;
  logic                     clr_err;
  logic [DATA_WIDTH-1:0]    data_in;
  logic [DATA_WIDTH-1:0]    data_out;
  logic [$clog2(DEPTH):0]   count;
  logic                     full;
  logic                     empty;
  logic                     almost_full;
  logic                     almost_empty;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output cs, wr_en, rd_en, flush, clr_err, data_in,
    input  data_out, count, full, empty, almost_full, almost_empty,
           overflow, underflow
  );

  modport slave (
    input  cs, wr_en, rd_en, flush, clr_err, data_in,
    output data_out, count, full, empty, almost_full, almost_empty,
           overflow, underflow
  );
endinterface

// File: rtl/param_sync_fifo.sv
// Parameterised synchronous FIFO with wrap-parity pointers, occupancy count,
// sticky overflow/underflow flags and optional first-word-fall-through output.
module param_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  param_sync_fifo_if.slave      bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C     = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_C     = PW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_count;
  logic                  r_ovf;
  logic                  r_unf;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_flush;
  logic                  w_clr;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_ovf_set;
  logic                  w_unf_set;
  logic [AW-1:0]         w_wr_idx;
  logic [AW-1:0]         w_rd_idx;

  assign w_full    = (r_count == DEPTH_C);
  assign w_empty   = (r_count == {PW{1'b0}});
  assign w_flush   = bus.cs & bus.flush;
  assign w_clr     = bus.cs & bus.clr_err;
  // Flush overrides any same-cycle transfer, including the memory write.
  assign w_wr_acc  = bus.cs & bus.wr_en & ~w_full  & ~w_flush;
  assign w_rd_acc  = bus.cs & bus.rd_en & ~w_empty & ~w_flush;
  assign w_ovf_set = bus.cs & bus.wr_en & w_full;
  assign w_unf_set = bus.cs & bus.rd_en & w_empty;
  assign w_wr_idx  = r_wr_ptr[AW-1:0];
  assign w_rd_idx  = r_rd_ptr[AW-1:0];

  assign bus.count        = r_count;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= AF_C);
  assign bus.almost_empty = (r_count <= AE_C);
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_unf;

  // Storage array; deliberately not reset so a reset only abandons contents.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[w_wr_idx] <= bus.data_in;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {PW{1'b0}};
    end else if (w_flush) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {PW{1'b0}};
    end else begin
      r_wr_ptr <= w_wr_acc ? (r_wr_ptr + PTR_ONE) : r_wr_ptr;
      r_rd_ptr <= w_rd_acc ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + PTR_ONE;
        2'b01:   r_count <= r_count - PTR_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags: a coincident set condition beats clr_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_ovf_set)  r_ovf <= 1'b1;
      else if (w_clr) r_ovf <= 1'b0;
      else            r_ovf <= r_ovf;
      if (w_unf_set)  r_unf <= 1'b1;
      else if (w_clr) r_unf <= 1'b0;
      else            r_unf <= r_unf;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.data_out = w_empty ? {DATA_WIDTH{1'b0}} : r_mem[w_rd_idx];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_dout;
      // Registered read port: loads only on an accepted read.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_dout <= {DATA_WIDTH{1'b0}};
        end else if (w_rd_acc) begin
          r_dout <= r_mem[w_rd_idx];
        end else begin
          r_dout <= r_dout;
        end
      end
      assign bus.data_out = r_dout;
    end
  endgenerate
endmodule
